axil_dma_cfg_writer: RTL

Parametrised AXI4-Lite write master that programs DMA control/status registers on behalf of the sequencer. It replaces the fixed 8-task writer with a table-driven engine: `NUM_TASK` request slots, each carrying its own register offset and write data. Requests are served in fixed priority with registered, handshake-stable address/data, and per-task completion and error reporting. An optional response watchdog is included. It sits between the sequencer's DMA-control FSM and the DMA's AXI-Lite slave port.

---
 rtl/axil_dma_cfg_writer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/axil_dma_cfg_writer.sv
// Table-driven AXI4-Lite write master that programs DMA registers from NUM_TASK request slots.
// Optional response watchdog is built when AXIL_WR_TIMEOUT_EN is defined.
module axil_dma_cfg_writer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_TASK  = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [ADDR_W-1:0]            m_axi_awaddr,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [DATA_W-1:0]            m_axi_wdata,
  output logic [DATA_W/8-1:0]          m_axi_wstrb,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  input  logic [1:0]                   m_axi_bresp,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [NUM_TASK-1:0]          task_req,
  input  logic [NUM_TASK*ADDR_W-1:0]   task_offset,
  input  logic [NUM_TASK*DATA_W-1:0]   task_data,
  output logic [NUM_TASK-1:0]          task_done,
  output logic [NUM_TASK-1:0]          task_err,
  output logic                         busy,
  input  logic [TIMEOUT_W-1:0]         timeout_cycles
);

  localparam int IDX_W = (NUM_TASK > 1) ? $clog2(NUM_TASK) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  sel_idx;
  logic [ADDR_W-1:0] sel_off;
  logic [DATA_W-1:0] sel_data;
  logic              aw_fin;
  logic              w_fin;
  logic              tmo_hit;

  // Descending scan so the lowest requesting slot wins.
  always_comb begin
    sel_idx  = '0;
    sel_off  = '0;
    sel_data = '0;
    for (int i = NUM_TASK - 1; i >= 0; i--) begin
      if (task_req[i]) begin
        sel_idx  = IDX_W'(i);
        sel_off  = task_offset[i*ADDR_W +: ADDR_W];
        sel_data = task_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign aw_fin = ~m_axi_awvalid | m_axi_awready;
  assign w_fin  = ~m_axi_wvalid  | m_axi_wready;

`ifdef AXIL_WR_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [TIMEOUT_W-1:0] tmo_inc;
  logic                 unused_bits;

  assign tmo_inc = (&tmo_cnt) ? tmo_cnt : tmo_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  assign tmo_hit = (timeout_cycles != '0) && (tmo_inc == timeout_cycles);
  assign unused_bits = m_axi_bresp[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      if (|task_req) tmo_cnt <= '0;
    end else if (state == ISSUE || state == RESP) begin
      tmo_cnt <= tmo_inc;
    end
  end
`else
  logic unused_bits;

  assign tmo_hit     = 1'b0;
  assign unused_bits = ^{m_axi_bresp[0], timeout_cycles};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      task_done     <= '0;
      task_err      <= '0;
      busy          <= 1'b0;
    end else begin
      task_done <= '0;
      task_err  <= '0;
      case (state)
        IDLE: begin
          if (|task_req) begin
            idx           <= sel_idx;
            m_axi_awaddr  <= base_addr + sel_off;
            m_axi_wdata   <= sel_data;
            m_axi_wstrb   <= '1;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (tmo_hit) begin
            m_axi_awvalid  <= 1'b0;
            m_axi_wvalid   <= 1'b0;
            task_done[idx] <= 1'b1;
            task_err[idx]  <= 1'b1;
            state          <= DONE;
          end else begin
            if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
            if (aw_fin && w_fin) begin
              m_axi_bready <= 1'b1;
              state        <= RESP;
            end
          end
        end
        RESP: begin
          if (tmo_hit) begin
            m_axi_bready   <= 1'b0;
            task_done[idx] <= 1'b1;
            task_err[idx]  <= 1'b1;
            state          <= DONE;
          end else if (m_axi_bvalid) begin
            m_axi_bready   <= 1'b0;
            task_done[idx] <= 1'b1;
            task_err[idx]  <= m_axi_bresp[1];
            state          <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
